// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared types and helpers for the multi-port register file.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    function automatic int num_regs(input int register_bits);
        return 1 << register_bits;
    endfunction

    // Low bit index of port `port` inside a packed bus of `width`-bit fields.
    function automatic int port_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_if
// Purpose  : Read, write, reserve and status signals of the register file.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_if #(
    parameter int WIDTH         = 16,
    parameter int REGISTER_BITS = 4,
    parameter int READ_PORTS    = 2
);
    logic                                ready;
    logic [READ_PORTS*REGISTER_BITS-1:0] rd_addr;
    logic [READ_PORTS*WIDTH-1:0]         rd_data;
    logic [READ_PORTS-1:0]               rd_busy;
    logic                                wa_en;
    logic [REGISTER_BITS-1:0]            wa_addr;
    logic [WIDTH-1:0]                    wa_data;
    logic                                wb_en;
    logic [REGISTER_BITS-1:0]            wb_addr;
    logic [WIDTH-1:0]                    wb_data;
    logic                                rsv_en;
    logic [REGISTER_BITS-1:0]            rsv_addr;
    logic                                wr_conflict;

    modport master (
        input  ready, rd_data, rd_busy, wr_conflict,
        output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               rsv_en, rsv_addr
    );

    modport slave (
        output ready, rd_data, rd_busy, wr_conflict,
        input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
               rsv_en, rsv_addr
    );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Per-register busy bits for in-flight producers, with read lookups.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int REGISTER_BITS = 4,
    parameter int READ_PORTS    = 2
) (
    input  wire logic                                clock,
    input  wire logic                                reset,
    input  wire logic                                clear,
    input  wire logic                                rsv_en,
    input  wire logic [REGISTER_BITS-1:0]            rsv_addr,
    input  wire logic                                clr_a_en,
    input  wire logic [REGISTER_BITS-1:0]            clr_a_addr,
    input  wire logic                                clr_b_en,
    input  wire logic [REGISTER_BITS-1:0]            clr_b_addr,
    input  wire logic [READ_PORTS*REGISTER_BITS-1:0] rd_addr,
    output logic      [READ_PORTS-1:0]               rd_busy
);
    localparam int c_NUM_REGS = num_regs(REGISTER_BITS);

    logic [c_NUM_REGS-1:0] r_busy;
    logic [c_NUM_REGS-1:0] w_busy_next;

    // Reserve is applied last so a new producer outranks a retiring write.
    always_comb begin
        w_busy_next = r_busy;
        if (clr_a_en) w_busy_next[clr_a_addr] = 1'b0;
        if (clr_b_en) w_busy_next[clr_b_addr] = 1'b0;
        if (rsv_en)   w_busy_next[rsv_addr]   = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_lookup
        localparam int c_AL = port_lo(k, REGISTER_BITS);
        assign rd_busy[k] = r_busy[rd_addr[c_AL +: REGISTER_BITS]];
    end

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-port register file with write arbitration, bypass and clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int REGISTER_BITS = 4,
    parameter int READ_PORTS    = 2,
    parameter int ZERO_REG      = 1,
    parameter int BYPASS        = 1
) (
    input wire logic clock,
    input wire logic reset,
    regfile_if.slave rf
);
    localparam int c_NUM_REGS = num_regs(REGISTER_BITS);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [REGISTER_BITS-1:0] r_clr_idx;
    logic [WIDTH-1:0]         r_mem [c_NUM_REGS];
    logic                     r_wr_conflict;
    logic                     w_ready;
    logic                     w_run;
    logic                     w_clearing;
    logic                     w_wa_ok;
    logic                     w_wb_ok;
    logic                     w_rsv_ok;
    logic                     w_same_addr;
    logic [READ_PORTS-1:0]    w_sb_busy;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        case (r_state)
            CLEAR:   if (r_clr_idx == {REGISTER_BITS{1'b1}}) w_state_next = RUN;
            RUN:     w_ready = 1'b1;
            default: w_state_next = CLEAR;
        endcase
    end

    assign w_run       = (r_state == RUN);
    assign w_clearing  = !w_run;
    assign w_wa_ok     = w_run && rf.wa_en && !((ZERO_REG != 0) && (rf.wa_addr == '0));
    assign w_wb_ok     = w_run && rf.wb_en && !((ZERO_REG != 0) && (rf.wb_addr == '0));
    assign w_rsv_ok    = w_run && rf.rsv_en && !((ZERO_REG != 0) && (rf.rsv_addr == '0));
    assign w_same_addr = (rf.wa_addr == rf.wb_addr);

    // Port B (load) takes the slot when both ports target the same register.
    always_ff @(posedge clock) begin
        if (r_state == CLEAR) begin
            r_mem[r_clr_idx] <= '0;
        end else begin
            if (w_wa_ok && !(w_wb_ok && w_same_addr)) r_mem[rf.wa_addr] <= rf.wa_data;
            if (w_wb_ok)                              r_mem[rf.wb_addr] <= rf.wb_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_conflict <= 1'b0;
        end else begin
            r_wr_conflict <= w_wa_ok && w_wb_ok && w_same_addr;
        end
    end

    regfile_scoreboard #(
        .REGISTER_BITS (REGISTER_BITS),
        .READ_PORTS    (READ_PORTS)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .clear      (w_clearing),
        .rsv_en     (w_rsv_ok),
        .rsv_addr   (rf.rsv_addr),
        .clr_a_en   (w_wa_ok),
        .clr_a_addr (rf.wa_addr),
        .clr_b_en   (w_wb_ok),
        .clr_b_addr (rf.wb_addr),
        .rd_addr    (rf.rd_addr),
        .rd_busy    (w_sb_busy)
    );

    for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
        localparam int c_AL = port_lo(k, REGISTER_BITS);
        localparam int c_DL = port_lo(k, WIDTH);

        logic [REGISTER_BITS-1:0] w_addr;
        logic [WIDTH-1:0]         w_data;
        logic                     w_busy;

        assign w_addr = rf.rd_addr[c_AL +: REGISTER_BITS];

        // A forwarded value is the producer's result, so it is never busy.
        always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            if (!w_run || ((ZERO_REG != 0) && (w_addr == '0))) begin
                w_data = '0;
            end else if ((BYPASS != 0) && rf.wb_en && (rf.wb_addr == w_addr)) begin
                w_data = rf.wb_data;
            end else if ((BYPASS != 0) && rf.wa_en && (rf.wa_addr == w_addr)) begin
                w_data = rf.wa_data;
            end else begin
                w_data = r_mem[w_addr];
                w_busy = w_sb_busy[k];
            end
        end

        assign rf.rd_data[c_DL +: WIDTH] = w_data;
        assign rf.rd_busy[k]             = w_busy;
    end

    assign rf.ready       = w_ready;
    assign rf.wr_conflict = r_wr_conflict;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Scoreboard bench; two instances (default and ZERO_REG=0/BYPASS=0)
//            share one stimulus stream and a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;
    localparam int W  = 16;
    localparam int RB = 4;
    localparam int RP = 2;
    localparam int N  = 16;

    typedef struct {
        logic                    rdy;
        logic [1:0][RP*W-1:0]    data;
        logic [1:0][RP-1:0]      busy;
        logic [1:0]              conf;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    regfile_if #(.WIDTH(W), .REGISTER_BITS(RB), .READ_PORTS(RP)) bus0 ();
    regfile_if #(.WIDTH(W), .REGISTER_BITS(RB), .READ_PORTS(RP)) bus1 ();

    assign bus1.rd_addr  = bus0.rd_addr;
    assign bus1.wa_en    = bus0.wa_en;
    assign bus1.wa_addr  = bus0.wa_addr;
    assign bus1.wa_data  = bus0.wa_data;
    assign bus1.wb_en    = bus0.wb_en;
    assign bus1.wb_addr  = bus0.wb_addr;
    assign bus1.wb_data  = bus0.wb_data;
    assign bus1.rsv_en   = bus0.rsv_en;
    assign bus1.rsv_addr = bus0.rsv_addr;

    regfile_mp #(.WIDTH(W), .REGISTER_BITS(RB), .READ_PORTS(RP), .ZERO_REG(1), .BYPASS(1))
        dut0 (.clock(clock), .reset(reset), .rf(bus0));
    regfile_mp #(.WIDTH(W), .REGISTER_BITS(RB), .READ_PORTS(RP), .ZERO_REG(0), .BYPASS(0))
        dut1 (.clock(clock), .reset(reset), .rf(bus1));

    // Stimulus for the coming cycle
    logic          s_reset;
    logic [RB-1:0] s_rd [RP];
    logic          s_wa_en, s_wb_en, s_rsv_en;
    logic [RB-1:0] s_wa_addr, s_wb_addr, s_rsv_addr;
    logic [W-1:0]  s_wa_data, s_wb_data;

    // Reference model: index 0 = default config, index 1 = no zero reg, no bypass
    logic [W-1:0] m_mem  [2][N];
    logic         m_busy [2][N];
    logic         m_conf [2];
    int           m_since;
    bit           m_known = 1'b0;
    bit           m_run   = 1'b0;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic void exp_read(input int c, input logic [RB-1:0] a,
                                     output logic [W-1:0] d, output logic b);
        bit zr  = (c == 0);
        bit byp = (c == 0);
        d = '0;
        b = 1'b0;
        if (!m_run || (zr && a == 0)) begin
            d = '0;
        end else if (byp && s_wb_en && s_wb_addr == a) begin
            d = s_wb_data;
        end else if (byp && s_wa_en && s_wa_addr == a) begin
            d = s_wa_data;
        end else begin
            d = m_mem[c][a];
            b = m_busy[c][a];
        end
    endfunction

    task automatic predict(output exp_t e);
        logic [W-1:0] d;
        logic         b;
        e.rdy = m_run;
        for (int c = 0; c < 2; c++) begin
            e.conf[c] = m_conf[c];
            for (int p = 0; p < RP; p++) begin
                exp_read(c, s_rd[p], d, b);
                e.data[c][p*W +: W] = d;
                e.busy[c][p]        = b;
            end
        end
    endtask

    task automatic model_edge();
        if (!s_reset) begin
            m_known = 1'b1;
            m_since = 0;
            m_run   = 1'b0;
            for (int c = 0; c < 2; c++) begin
                m_conf[c] = 1'b0;
                for (int r = 0; r < N; r++) m_busy[c][r] = 1'b0;
            end
        end else if (!m_run) begin
            m_since++;
            if (m_since >= N) begin
                m_run = 1'b1;
                for (int c = 0; c < 2; c++)
                    for (int r = 0; r < N; r++) m_mem[c][r] = '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                bit zr   = (c == 0);
                bit a_ok = s_wa_en && !(zr && s_wa_addr == 0);
                bit b_ok = s_wb_en && !(zr && s_wb_addr == 0);
                if (a_ok) m_mem[c][s_wa_addr] = s_wa_data;
                if (b_ok) m_mem[c][s_wb_addr] = s_wb_data;
                if (a_ok) m_busy[c][s_wa_addr] = 1'b0;
                if (b_ok) m_busy[c][s_wb_addr] = 1'b0;
                if (s_rsv_en && !(zr && s_rsv_addr == 0)) m_busy[c][s_rsv_addr] = 1'b1;
                m_conf[c] = a_ok && b_ok && (s_wa_addr == s_wb_addr);
            end
        end
    endtask

    task automatic cycle();
        exp_t e;
        @(negedge clock);
        #1;
        reset         = s_reset;
        bus0.rd_addr  = {s_rd[1], s_rd[0]};
        bus0.wa_en    = s_wa_en;
        bus0.wa_addr  = s_wa_addr;
        bus0.wa_data  = s_wa_data;
        bus0.wb_en    = s_wb_en;
        bus0.wb_addr  = s_wb_addr;
        bus0.wb_data  = s_wb_data;
        bus0.rsv_en   = s_rsv_en;
        bus0.rsv_addr = s_rsv_addr;
        if (m_known) begin
            predict(e);
            q.push_back(e);
        end
        model_edge();
    endtask

    task automatic idle();
        s_wa_en  = 1'b0;
        s_wb_en  = 1'b0;
        s_rsv_en = 1'b0;
    endtask

    task automatic rd(input logic [RB-1:0] a0, input logic [RB-1:0] a1);
        s_rd[0] = a0;
        s_rd[1] = a1;
    endtask

    // Monitor: compares every cycle for which an expectation was queued
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ready0",       64'(bus0.ready),       64'(e.rdy));
                chk("ready1",       64'(bus1.ready),       64'(e.rdy));
                chk("rd_data0",     64'(bus0.rd_data),     64'(e.data[0]));
                chk("rd_data1",     64'(bus1.rd_data),     64'(e.data[1]));
                chk("rd_busy0",     64'(bus0.rd_busy),     64'(e.busy[0]));
                chk("rd_busy1",     64'(bus1.rd_busy),     64'(e.busy[1]));
                chk("wr_conflict0", 64'(bus0.wr_conflict), 64'(e.conf[0]));
                chk("wr_conflict1", 64'(bus1.wr_conflict), 64'(e.conf[1]));
            end
        end
    end

    initial begin
        s_reset = 1'b0;
        s_wa_addr = '0; s_wb_addr = '0; s_rsv_addr = '0;
        s_wa_data = '0; s_wb_data = '0;
        idle();
        rd(0, 0);
        repeat (3) cycle();

        // Writes during the sweep must be dropped
        s_reset = 1'b1;
        s_wa_en = 1'b1; s_wa_addr = 4'd5; s_wa_data = 16'h1234;
        rd(5, 0);
        repeat (2) cycle();
        idle();
        repeat (16) cycle();

        // Write r3, read same cycle and next
        s_wa_en = 1'b1; s_wa_addr = 4'd3; s_wa_data = 16'hBEEF;
        rd(3, 5);
        cycle();
        idle();
        cycle();

        // r0 write plus reserve
        s_wa_en = 1'b1; s_wa_addr = 4'd0; s_wa_data = 16'hFFFF;
        s_rsv_en = 1'b1; s_rsv_addr = 4'd0;
        rd(0, 0);
        cycle();
        idle();
        cycle();

        // Same-address conflict
        s_wa_en = 1'b1; s_wa_addr = 4'd7; s_wa_data = 16'h1111;
        s_wb_en = 1'b1; s_wb_addr = 4'd7; s_wb_data = 16'h2222;
        rd(7, 3);
        cycle();
        idle();
        repeat (2) cycle();

        // Scoreboard: reserve, retire, reserve+write
        s_rsv_en = 1'b1; s_rsv_addr = 4'd9;
        rd(9, 7);
        cycle();
        idle();
        cycle();
        s_wb_en = 1'b1; s_wb_addr = 4'd9; s_wb_data = 16'h00AA;
        cycle();
        idle();
        cycle();
        s_rsv_en = 1'b1; s_rsv_addr = 4'd9;
        s_wa_en = 1'b1; s_wa_addr = 4'd9; s_wa_data = 16'h0001;
        cycle();
        idle();
        cycle();

        // Mid-operation reset with live data and a busy register
        s_wa_en = 1'b1; s_wa_addr = 4'd2; s_wa_data = 16'h5A5A;
        s_rsv_en = 1'b1; s_rsv_addr = 4'd4;
        rd(2, 4);
        cycle();
        idle();
        cycle();
        s_reset = 1'b0;
        cycle();
        s_reset = 1'b1;
        repeat (18) cycle();

        // Random traffic, reads biased toward the write addresses
        for (int i = 0; i < 600; i++) begin
            s_reset    = ($urandom_range(0, 199) != 0);
            s_wa_en    = ($urandom_range(0, 1) == 1);
            s_wb_en    = ($urandom_range(0, 1) == 1);
            s_rsv_en   = ($urandom_range(0, 2) == 0);
            s_wa_addr  = RB'($urandom_range(0, N-1));
            s_wb_addr  = ($urandom_range(0, 3) == 0) ? s_wa_addr : RB'($urandom_range(0, N-1));
            s_rsv_addr = ($urandom_range(0, 2) == 0) ? s_wa_addr : RB'($urandom_range(0, N-1));
            s_wa_data  = W'($urandom);
            s_wb_data  = W'($urandom);
            for (int p = 0; p < RP; p++) begin
                case ($urandom_range(0, 3))
                    0:       s_rd[p] = s_wa_addr;
                    1:       s_rd[p] = s_wb_addr;
                    default: s_rd[p] = RB'($urandom_range(0, N-1));
                endcase
            end
            cycle();
        end

        idle();
        s_reset = 1'b1;
        cycle();
        repeat (3) @(negedge clock);
        #5;
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, successor to the CPU's original 16×16 register file. Provides N combinational read ports, two prioritised write ports (ALU writeback and load writeback), optional same-cycle write-to-read bypass, a per-register busy scoreboard for in-flight producers, and a hardware clear sweep after reset. Sits between decode (reads, reserves) and the writeback stages.

## Interface
- WIDTH, 16: data width in bits.
- REGISTER_BITS, 4: address width; NUM_REGS = 2**REGISTER_BITS.
- READ_PORTS, 2: number of read ports, 1 to 4.
- ZERO_REG, 1: 1 means r0 reads 0, ignores writes, and is never busy.
- BYPASS, 1: 1 means the same-cycle write is forwarded to matching reads.

- clock  in  1  clock, rising edge. Already decided.
- reset  in  1  synchronous, active-low. Already decided.
- ready  out  1  high once the clear sweep is done.
- rd_addr  in  READ_PORTS*REGISTER_BITS  packed read addresses; port k at [k*RB +: RB].
- rd_data  out  READ_PORTS*WIDTH  packed read data.
- rd_busy  out  READ_PORTS  busy bit of each read address.
- wa_en  in  1  write port A (ALU) enable.
- wa_addr  in  REGISTER_BITS  write port A address.
- wa_data  in  WIDTH  write port A data.
- wb_en  in  1  write port B (load) enable.
- wb_addr  in  REGISTER_BITS  write port B address.
- wb_data  in  WIDTH  write port B data.
- rsv_en  in  1  reserve request: mark rsv_addr busy.
- rsv_addr  in  REGISTER_BITS  address to reserve.
- wr_conflict  out  1  registered pulse: both write ports hit the same writable address last cycle.

## Operation
- The FSM has two states, CLEAR and RUN.
- While reset=0 at a clock edge:
  - state←CLEAR, clr_idx←0;
  - all busy bits←0;
  - wr_conflict←0.
- CLEAR state:
  - Each cycle: reg[clr_idx]←0, clr_idx←clr_idx+1.
  - When clr_idx reaches NUM_REGS−1, the next state is RUN.
  - During CLEAR: ready=0, all rd_data=0, all rd_busy=0. Writes and reserves are ignored.
- RUN state: ready=1.
- Writes, at the clock edge:
  - An enabled port writes its address, unless the address is 0 and ZERO_REG=1.
  - If A and B target the same address, B wins and wr_conflict←1 on the next cycle.
  - A write clears the busy bit of its address.
- Reserve:
  - rsv_en sets busy[rsv_addr].
  - If a reserve and a write hit the same address in the same cycle, the reserve wins and busy stays 1 (a new producer).
  - A reserve of r0 is ignored when ZERO_REG=1.
- Reads are combinational from the current array. Resolution order per port:
  1. Address 0 with ZERO_REG=1: data 0, busy 0.
  2. BYPASS=1 and wb_en and a wb_addr match: wb_data, busy 0.
  3. BYPASS=1 and wa_en and a wa_addr match: wa_data, busy 0.
  4. Otherwise: the array value and the stored busy bit.
- Reset during CLEAR or RUN restarts the sweep from index 0. Array contents are not otherwise guaranteed.

## Timing
- Reset outputs: ready=0, rd_data=0, rd_busy=0, wr_conflict=0.
- ready rises exactly NUM_REGS clock edges after the first edge with reset=1 (16 for defaults).
- Write latency: one edge. Visible the same cycle via bypass, or the cycle after via the array.
- Reserve latency: one edge. rd_busy reflects it the cycle after.
- wr_conflict is high for exactly one cycle per conflicting cycle.
- Read ports have no handshake and no stall. The producer must not reuse a port during CLEAR.

## Structure
- Package regfile_pkg holds:
  - the state enum (CLEAR, RUN);
  - the function computing NUM_REGS from REGISTER_BITS;
  - the port-slice helper for packed buses.
- Sub-module regfile_scoreboard holds the NUM_REGS-bit busy vector. Its inputs are reserve, the two write-clear ports and reset/CLEAR; its outputs are the per-port busy lookups.
- The top level holds the array, the clear FSM, write arbitration and bypass muxes.

## Test plan
- Clear sweep: hold reset=0 for 3 cycles, release, then write r5=0x1234 during CLEAR. ready rises after 16 edges, and r5 reads 0x0000 once RUN is reached.
- Basic write/read: in RUN, wa writes r3=0xBEEF. The same cycle, rd port 0 on r3 returns 0xBEEF via bypass. The next cycle returns 0xBEEF with BYPASS=0.
- Zero register: wa writes r0=0xFFFF with rsv_en on r0. r0 reads 0x0000 and busy 0. With ZERO_REG=0, r0 reads 0xFFFF.
- Conflict: wa r7=0x1111 and wb r7=0x2222 in the same cycle. r7 reads 0x2222, and wr_conflict=1 for one cycle.
- Scoreboard:
  - Reserve r9: rd_busy is 1 the next cycle.
  - wb writes r9=0x00AA: busy clears after the write edge.
  - Reserve r9 and write r9 in the same cycle: busy stays 1.
- Mid-operation reset: assert reset during RUN with r2=0x5A5A and busy[4]=1. busy is 0 immediately, ready drops, the sweep restarts, and r2 reads 0 after ready.
